// File: rtl/tmr_scrub_pkg.sv
// tmr_scrub_pkg: shared types and helpers for the TMR scrub bank.
// Holds the scrubber state enum, width helpers and a saturating increment.
package tmr_scrub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scrub_state_t;

    // Widest counter the saturating helper supports.
    localparam int SAT_W = 32;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int timer_w(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] v,
        input logic [SAT_W-1:0] maxv
    );
        return (v == maxv) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/tmr_vote_word.sv
// tmr_vote_word: bitwise 2-of-3 majority voter for one word.
// Ports: a/b/c copies in, vote out, mismatch high if any copy != vote.
module tmr_vote_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] vote,
    output logic             mismatch
);

    assign vote = (a & b) | (b & c) | (c & a);

    assign mismatch = (a != vote) || (b != vote) || (c != vote);

endmodule

// File: rtl/tmr_scrub_bank.sv
// tmr_scrub_bank: triplicated config word bank, voted reads, periodic scrub.
// Ports: CP/CDN clk+async reset, wr_*/rd_* user access, clr_cnt, seu_cnt,
// seu_pulse, scrub_busy. Define TMR_SEU_INJECT_EN to add inj_* ports.
module tmr_scrub_bank
    import tmr_scrub_pkg::*;
#(
    parameter int NWORDS       = 16,
    parameter int WIDTH        = 8,
    parameter int SCRUB_PERIOD = 256,
    parameter int CNT_W        = 8
) (
    input  logic                      CP,
    input  logic                      CDN,
    input  logic                      wr_en,
    input  logic [$clog2(NWORDS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [$clog2(NWORDS)-1:0] rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    input  logic                      clr_cnt,
    output logic [CNT_W-1:0]          seu_cnt,
    output logic                      seu_pulse,
    output logic                      scrub_busy
`ifdef TMR_SEU_INJECT_EN
    ,
    input  logic                      inj_en,
    input  logic [1:0]                inj_copy,
    input  logic [$clog2(NWORDS)-1:0] inj_addr,
    input  logic [$clog2(WIDTH)-1:0]  inj_bit
`endif
);

    localparam int AW = addr_w(NWORDS);
    localparam int TW = timer_w(SCRUB_PERIOD);
    localparam logic [AW-1:0]    LAST    = AW'(NWORDS - 1);
    localparam logic [TW-1:0]    TC      = TW'(SCRUB_PERIOD - 1);
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    logic [WIDTH-1:0] mem0 [NWORDS];
    logic [WIDTH-1:0] mem1 [NWORDS];
    logic [WIDTH-1:0] mem2 [NWORDS];

    scrub_state_t  state;
    logic [AW-1:0] scan_addr;
    logic [TW-1:0] timer;

    logic [WIDTH-1:0] rd_vote;
    logic             rd_mis;
    logic [WIDTH-1:0] sc_vote;
    logic             sc_mis;
    logic             fix;

    tmr_vote_word #(.WIDTH(WIDTH)) u_rd_vote (
        .a       (mem0[rd_addr]),
        .b       (mem1[rd_addr]),
        .c       (mem2[rd_addr]),
        .vote    (rd_vote),
        .mismatch(rd_mis)
    );

    tmr_vote_word #(.WIDTH(WIDTH)) u_sc_vote (
        .a       (mem0[scan_addr]),
        .b       (mem1[scan_addr]),
        .c       (mem2[scan_addr]),
        .vote    (sc_vote),
        .mismatch(sc_mis)
    );

    // A user write to the word under scan replaces the repair entirely.
    assign fix = (state == SCAN) && sc_mis &&
                 !(wr_en && (wr_addr == scan_addr));

    // Later assignments override earlier ones on the same word/copy:
    // scrub write-back, then injection, then user write.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
                mem2[i] <= '0;
            end
            rd_data    <= '0;
            seu_cnt    <= '0;
            seu_pulse  <= 1'b0;
            scrub_busy <= 1'b0;
            timer      <= '0;
            scan_addr  <= '0;
            state      <= IDLE;
        end else begin
            rd_data   <= rd_vote;
            seu_pulse <= fix;

            if (clr_cnt) begin
                seu_cnt <= '0;
            end else if (fix) begin
                seu_cnt <= CNT_W'(sat_inc(SAT_W'(seu_cnt), CNT_MAX));
            end

            if (fix) begin
                mem0[scan_addr] <= sc_vote;
                mem1[scan_addr] <= sc_vote;
                mem2[scan_addr] <= sc_vote;
            end

`ifdef TMR_SEU_INJECT_EN
            if (inj_en) begin
                case (inj_copy)
                    2'd0: mem0[inj_addr] <= mem0[inj_addr] ^
                                            (WIDTH'(1) << inj_bit);
                    2'd1: mem1[inj_addr] <= mem1[inj_addr] ^
                                            (WIDTH'(1) << inj_bit);
                    2'd2: mem2[inj_addr] <= mem2[inj_addr] ^
                                            (WIDTH'(1) << inj_bit);
                    default: ;
                endcase
            end
`endif

            if (wr_en) begin
                mem0[wr_addr] <= wr_data;
                mem1[wr_addr] <= wr_data;
                mem2[wr_addr] <= wr_data;
            end

            case (state)
                IDLE: begin
                    if (timer == TC) begin
                        state      <= SCAN;
                        scan_addr  <= '0;
                        timer      <= '0;
                        scrub_busy <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SCAN: begin
                    scan_addr <= scan_addr + AW'(1);
                    if (scan_addr == LAST) begin
                        state      <= IDLE;
                        timer      <= '0;
                        scrub_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_scrub_bank.sv
// tb_tmr_scrub_bank: directed bench for tmr_scrub_bank.
// Vector table for write/read, hand sequences for scrub, collision, reset.
module tb_tmr_scrub_bank;

    localparam int NW = 16;
    localparam int W  = 8;
    localparam int SP = 20;
    localparam int CW = 2;
    localparam int LIM = 400;

    logic          CP = 1'b0;
    logic          CDN;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic [3:0]    rd_addr;
    logic [W-1:0]  rd_data;
    logic          clr_cnt;
    logic [CW-1:0] seu_cnt;
    logic          seu_pulse;
    logic          scrub_busy;
`ifdef TMR_SEU_INJECT_EN
    logic          inj_en;
    logic [1:0]    inj_copy;
    logic [3:0]    inj_addr;
    logic [2:0]    inj_bit;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CP = ~CP;

    tmr_scrub_bank #(
        .NWORDS(NW), .WIDTH(W), .SCRUB_PERIOD(SP), .CNT_W(CW)
    ) dut (
        .CP        (CP),
        .CDN       (CDN),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .clr_cnt   (clr_cnt),
        .seu_cnt   (seu_cnt),
        .seu_pulse (seu_pulse),
        .scrub_busy(scrub_busy)
`ifdef TMR_SEU_INJECT_EN
        ,
        .inj_en    (inj_en),
        .inj_copy  (inj_copy),
        .inj_addr  (inj_addr),
        .inj_bit   (inj_bit)
`endif
    );

    typedef struct {
        logic         we;
        logic [3:0]   wa;
        logic [W-1:0] wd;
        logic [3:0]   ra;
        logic [W-1:0] er;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(inout int pulses);
        @(negedge CP);
        if (seu_pulse) pulses++;
    endtask

    task automatic wait_busy(inout int pulses);
        int n;
        n = 0;
        while (!scrub_busy && n < LIM) begin
            step(pulses);
            n++;
        end
        chk("wait_busy_bound", 32'(n < LIM), 32'd1);
    endtask

    // Finish the current (or next) pass and two settle cycles.
    task automatic run_pass(output int pulses);
        int n;
        pulses = 0;
        n = 0;
        while (!scrub_busy && n < LIM) begin
            step(pulses);
            n++;
        end
        while (scrub_busy && n < LIM) begin
            step(pulses);
            n++;
        end
        repeat (2) step(pulses);
        chk("pass_bound", 32'(n < LIM), 32'd1);
    endtask

    task automatic count_to_busy(output int n);
        n = 0;
        while (n < LIM) begin
            @(negedge CP);
            n++;
            if (scrub_busy) break;
        end
    endtask

    // Flip one stored bit; takes one clock either way.
    task automatic upset(input int cp, input int a, input int b);
`ifdef TMR_SEU_INJECT_EN
        inj_en   = 1'b1;
        inj_copy = cp[1:0];
        inj_addr = a[3:0];
        inj_bit  = b[2:0];
        @(negedge CP);
        inj_en   = 1'b0;
`else
        case (cp)
            0: dut.mem0[a][b] = ~dut.mem0[a][b];
            1: dut.mem1[a][b] = ~dut.mem1[a][b];
            default: dut.mem2[a][b] = ~dut.mem2[a][b];
        endcase
        @(negedge CP);
`endif
    endtask

    initial begin
        int n;
        int p;
        int p2;

        vt[0] = '{1'b1, 4'd3,  8'hA5, 4'd3,  8'h00};
        vt[1] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'hA5};
        vt[2] = '{1'b1, 4'd7,  8'h3C, 4'd3,  8'hA5};
        vt[3] = '{1'b1, 4'd3,  8'h5A, 4'd7,  8'h3C};
        vt[4] = '{1'b1, 4'd0,  8'hFF, 4'd3,  8'h5A};
        vt[5] = '{1'b1, 4'd15, 8'h81, 4'd0,  8'hFF};
        vt[6] = '{1'b1, 4'd0,  8'h00, 4'd15, 8'h81};
        vt[7] = '{1'b0, 4'd0,  8'h00, 4'd0,  8'h00};
        vt[8] = '{1'b1, 4'd3,  8'h11, 4'd3,  8'h5A};
        vt[9] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'h11};

        CDN = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        clr_cnt = 1'b0;
`ifdef TMR_SEU_INJECT_EN
        inj_en = 1'b0;
        inj_copy = '0;
        inj_addr = '0;
        inj_bit = '0;
`endif

        repeat (2) @(negedge CP);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_seu_cnt", 32'(seu_cnt), 32'h0);
        chk("rst_pulse", 32'(seu_pulse), 32'h0);
        chk("rst_busy", 32'(scrub_busy), 32'h0);

        CDN = 1'b1;
        count_to_busy(n);
        chk("first_pass_delay", 32'(n), 32'(SP));

        for (int i = 0; i < 10; i++) begin
            wr_en   = vt[i].we;
            wr_addr = vt[i].wa;
            wr_data = vt[i].wd;
            rd_addr = vt[i].ra;
            @(negedge CP);
            chk($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vt[i].er));
            chk($sformatf("vec%0d_pulse", i), 32'(seu_pulse), 32'h0);
        end
        wr_en = 1'b0;

        run_pass(p);
        run_pass(p2);
        chk("clean_pass_pulses", 32'(p + p2), 32'd0);
        chk("clean_pass_cnt", 32'(seu_cnt), 32'd0);

        // Single-bit upset in copy 1 of addr 5.
        rd_addr = 4'd5;
        upset(1, 5, 2);
        chk("upset_planted", 32'(dut.mem1[5]), 32'h04);
        @(negedge CP);
        chk("upset_rd_voted", 32'(rd_data), 32'h00);
        run_pass(p);
        chk("single_pulses", 32'(p), 32'd1);
        chk("single_cnt", 32'(seu_cnt), 32'd1);
        chk("single_fixed", 32'(dut.mem1[5]), 32'h00);

        // Two bits of one word, counted once.
        upset(0, 2, 0);
        upset(0, 2, 7);
        chk("multi_planted", 32'(dut.mem0[2]), 32'h81);
        run_pass(p);
        chk("multi_pulses", 32'(p), 32'd1);
        chk("multi_cnt", 32'(seu_cnt), 32'd2);
        chk("multi_fixed", 32'(dut.mem0[2]), 32'h00);

        // User write lands on addr 4 as the scan reaches it.
        p = 0;
        upset(2, 4, 5);
        wait_busy(p);
        repeat (4) step(p);
        wr_en   = 1'b1;
        wr_addr = 4'd4;
        wr_data = 8'h3C;
        step(p);
        wr_en = 1'b0;
        run_pass(p2);
        chk("coll_pulses", 32'(p + p2), 32'd0);
        chk("coll_cnt", 32'(seu_cnt), 32'd2);
        chk("coll_c0", 32'(dut.mem0[4]), 32'h3C);
        chk("coll_c1", 32'(dut.mem1[4]), 32'h3C);
        chk("coll_c2", 32'(dut.mem2[4]), 32'h3C);

        // Clear, then five upsets in one pass saturate a 2-bit counter.
        clr_cnt = 1'b1;
        @(negedge CP);
        clr_cnt = 1'b0;
        chk("clr_cnt", 32'(seu_cnt), 32'd0);
        for (int a = 8; a < 13; a++) upset(0, a, 1);
        run_pass(p);
        chk("sat_pulses", 32'(p), 32'd5);
        chk("sat_cnt", 32'(seu_cnt), 32'd3);

        // Clear on the same edge as a correction at addr 6.
        p = 0;
        upset(1, 6, 3);
        wait_busy(p);
        repeat (6) step(p);
        clr_cnt = 1'b1;
        @(negedge CP);
        clr_cnt = 1'b0;
        chk("clr_coinc_pulse", 32'(seu_pulse), 32'd1);
        chk("clr_coinc_cnt", 32'(seu_cnt), 32'd0);
        run_pass(p);

        // Reset in the middle of a pass.
        upset(2, 13, 0);
        rd_addr = 4'd3;
        run_pass(p);
        chk("pre_rst_pulses", 32'(p), 32'd1);
        chk("pre_rst_cnt", 32'(seu_cnt), 32'd1);
        chk("pre_rst_rd", 32'(rd_data), 32'h11);
        p = 0;
        wait_busy(p);
        repeat (3) @(negedge CP);
        CDN = 1'b0;
        #1;
        chk("midrst_rd", 32'(rd_data), 32'h0);
        chk("midrst_cnt", 32'(seu_cnt), 32'h0);
        chk("midrst_busy", 32'(scrub_busy), 32'h0);
        @(negedge CP);
        CDN = 1'b1;
        count_to_busy(n);
        chk("rst_pass_delay", 32'(n), 32'(SP));
        chk("rst_mem_cleared", 32'(rd_data), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmr_scrub_bank.md
Name: tmr_scrub_bank

Overview:
- Triplicated configuration register bank with a periodic scrubber.
- Hosts NWORDS words, stored as three independent copies each. Reads return the bitwise majority vote of the three copies.
- A background FSM walks every word, compares each copy to the vote, writes back corrected values and counts upset words.
- Sits between the config command decoder and the chip-level config outputs. It is the read/repair counterpart to the per-bit TMR enable flops.

Parameters:
- NWORDS, 16, number of words; must be a power of 2, minimum 2.
- WIDTH, 8, bits per word.
- SCRUB_PERIOD, 256, idle cycles between scrub passes; minimum 2.
- CNT_W, 8, width of the saturating upset counter.

Ports:
- CP  in  1  clock, rising edge.
- CDN  in  1  asynchronous active-low reset.
- wr_en  in  1  user write strobe.
- wr_addr  in  $clog2(NWORDS)  write address.
- wr_data  in  WIDTH  write data; written to all three copies.
- rd_addr  in  $clog2(NWORDS)  read address.
- rd_data  out  WIDTH  voted word at rd_addr, registered.
- clr_cnt  in  1  synchronous clear of seu_cnt.
- seu_cnt  out  CNT_W  count of words found with any copy mismatch; saturating.
- seu_pulse  out  1  one-cycle pulse for each corrected word.
- scrub_busy  out  1  high while a scrub pass is in progress.

Behaviour:
- Reset (CDN low, asynchronous):
  - All copies, rd_data, seu_cnt, seu_pulse, scrub_busy and the period timer go to 0.
  - FSM goes to IDLE.
  - Effect is immediate; any pass in progress is abandoned.
- Write: wr_en at edge k updates all three copies at addr at edge k.
- Read: rd_data at edge k+1 equals the vote of the copies as they stand after edge k. Latency is 1 cycle.
  - Read-during-write to the same address returns the new data one cycle after the write edge.
- Vote is bitwise majority (a&b)|(b&c)|(c&a).
- FSM:
  - IDLE: timer counts 0..SCRUB_PERIOD-1. At terminal count, go to SCAN with scan_addr=0. scrub_busy=0.
  - SCAN: one word per cycle.
    - If any copy differs from the vote, write the vote to all three copies at the same edge, pulse seu_pulse the next cycle, and increment seu_cnt.
    - scan_addr increments each cycle. After word NWORDS-1, go to IDLE with the timer cleared. scrub_busy=1.
  - A pass therefore takes exactly NWORDS cycles. A new pass starts SCRUB_PERIOD cycles after the pass ends.
- Counting:
  - One count per word per pass, irrespective of how many bits are upset.
  - seu_cnt saturates at 2^CNT_W-1 and does not wrap; seu_pulse still fires when saturated.
- Collisions:
  - wr_en with wr_addr==scan_addr in SCAN: the user write wins, scrub write-back is suppressed, and there is no count or pulse.
  - The scan still advances.
- clr_cnt together with an increment: clear wins, seu_cnt=0.
- Multi-bit disagreement in one word: each bit is voted independently. The word is corrected and counted once.
- CDN deassertion is expected to be synchronous to CP upstream; the block does not resynchronise it.

Optional Feature:
- TMR_SEU_INJECT_EN defined: adds the following ports.
  - inj_en in 1
  - inj_copy in 2 (0..2; 3 is ignored)
  - inj_addr in $clog2(NWORDS)
  - inj_bit in $clog2(WIDTH)
- Behaviour with the macro defined:
  - inj_en inverts one bit of one copy at that edge.
  - Priority on the same word and copy: user write > injection > scrub write-back.
- Macro undefined: the ports are absent and there is no injection logic.

Decomposition:
- tmr_scrub_pkg holds:
  - FSM state enum {IDLE, SCAN}.
  - Localparam helpers for address and timer widths.
  - Saturating-increment function.
- Sub-module tmr_vote_word: WIDTH-parameterised combinational 3-input bitwise majority voter with a per-word mismatch output.
  - Instanced once for the read path and once for the scan path.

Test Plan:
- Reset: drive CDN low mid-SCAN with words preloaded -> rd_data=0, seu_cnt=0, scrub_busy=0 immediately; after release the first pass starts exactly SCRUB_PERIOD cycles later.
- Write/read: write 0xA5 to addr 3, set rd_addr=3 -> rd_data=0xA5 one cycle after the write edge; no seu_pulse over a full pass.
- Single upset (inject): flip bit 2 of copy 1 at addr 5 holding 0x00 -> rd_data stays 0x00; the next pass corrects the word; seu_pulse fires once; seu_cnt=1; copy 1 reads back 0x00.
- Multi-bit upset: flip bits 0 and 7 of copy 0 at addr 2 -> one correction, seu_cnt incremented by 1.
- Collision: inject at addr 4, then wr_en to addr 4 with 0x3C in the same cycle the scan reaches addr 4 -> all copies 0x3C, no count.
- Saturation/clear: CNT_W=2, upset 5 words in one pass -> seu_cnt=3 with 5 pulses; clr_cnt coincident with a correction -> seu_cnt=0.
